// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size encodings, per-mode constants, GF(2^8) helpers
// and the S-box, computed as inverse-plus-affine rather than a lookup table.
package aes_pkg;

   localparam int KEY_W_MAX = 256;
   localparam int NR_MAX    = 14;

   typedef enum logic [1:0] {
      MODE_AES128 = 2'b00,
      MODE_AES192 = 2'b01,
      MODE_AES256 = 2'b10
   } aes_mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } ks_state_e;

   // The reserved encoding 2'b11 falls through to the AES-128 constants.
   function automatic logic [3:0] nk_of(logic [1:0] mode);
      case (mode)
         MODE_AES192: return 4'd6;
         MODE_AES256: return 4'd8;
         default:     return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(logic [1:0] mode);
      case (mode)
         MODE_AES192: return 4'd12;
         MODE_AES256: return 4'd14;
         default:     return 4'd10;
      endcase
   endfunction

   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

   // x^254 is the multiplicative inverse (and maps 0 to 0).
   function automatic logic [7:0] sbox(logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_schedule_iter_if.sv
// Job request and round-key read bus of the iterative AES key schedule.
interface aes_key_schedule_iter_if #(
   parameter int KEY_W = 256,
   parameter int IDX_W = 4
);
   logic             start_valid_i;
   logic             start_ready_o;
   logic [1:0]       mode_i;
   logic [KEY_W-1:0] key_i;
   logic             busy_o;
   logic             done_o;
   logic             keys_valid_o;
   logic [3:0]       nr_o;
   logic [IDX_W-1:0] rk_idx_i;
   logic [127:0]     rk_o;

   modport master (
      output start_valid_i, mode_i, key_i, rk_idx_i,
      input  start_ready_o, busy_o, done_o, keys_valid_o, nr_o, rk_o
   );

   modport slave (
      input  start_valid_i, mode_i, key_i, rk_idx_i,
      output start_ready_o, busy_o, done_o, keys_valid_o, nr_o, rk_o
   );
endinterface

// File: rtl/aes_subword.sv
// 32-bit SubWord: four parallel S-boxes, shared with the cipher round logic.
module aes_subword
   import aes_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] sub_word
);

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      assign sub_word[8*b +: 8] = sbox(word[8*b +: 8]);
   end

endmodule

// File: rtl/aes_key_schedule_iter.sv
// Word-serial AES-128/192/256 key expansion with round-key storage and a
// registered indexed read port.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | ready for a job; stored schedule served if keys_valid_o
//   ST_EXPAND | one schedule word w[i] produced and stored per clock
module aes_key_schedule_iter
   import aes_pkg::*;
#(
   parameter int KEY_W  = 256,
   parameter int NR_MAX = 14,
   parameter int IDX_W  = 4
) (
   input logic                   clk_i,
   input logic                   rst_i,
   aes_key_schedule_iter_if.slave ks
);

   localparam int WORDS = 4 * (NR_MAX + 1);
   localparam int AW    = $clog2(WORDS);

   ks_state_e      state_q, state_d;
   logic           accept;
   logic           last_word;
   logic [1:0]     mode_q;
   logic [AW-1:0]  widx_q;
   logic [AW-1:0]  last_idx;
   logic [2:0]     nk_cnt_q;
   logic [7:0]     rcon_q;
   logic           done_q;
   logic           valid_q;
   logic [3:0]     nr_q;
   logic [127:0]   rk_q;
   logic [127:0]   rk_next;

   logic [31:0]    mem [WORDS];
   logic [31:0]    win_q [8];
   logic [31:0]    key_w [8];
   logic [2:0]     load_off;
   logic [31:0]    prev_w, back_w, sub_in, sub_out, t_w, new_w;
   logic           rot_phase, sub_phase;
   logic [IDX_W-1:0] rk_idx;

   for (genvar j = 0; j < 8; j++) begin : g_key
      assign key_w[j] = ks.key_i[KEY_W-1-32*j -: 32];
   end

   // nk_cnt_q counts down to the next i mod Nk == 0 position.
   assign last_idx  = AW'({nr_of(mode_q), 2'b11});
   assign last_word = (widx_q == last_idx);
   assign rot_phase = (nk_cnt_q == 3'd0);
   assign sub_phase = (mode_q == MODE_AES256) && (nk_cnt_q == 3'd4);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ks.start_valid_i) begin
               accept  = 1'b1;
               state_d = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            if (last_word) state_d = ST_IDLE;
         end
      endcase
   end

   // Window keeps w[i-1] in slot 7 and w[i-Nk] in slot 8-Nk.
   assign prev_w = win_q[7];
   always_comb begin
      case (mode_q)
         MODE_AES192: back_w = win_q[2];
         MODE_AES256: back_w = win_q[0];
         default:     back_w = win_q[4];
      endcase
   end

   assign sub_in = rot_phase ? {prev_w[23:0], prev_w[31:24]} : prev_w;
   assign t_w    = rot_phase ? (sub_out ^ {rcon_q, 24'h0}) :
                   sub_phase ? sub_out : prev_w;
   assign new_w  = back_w ^ t_w;

   aes_subword u_subword (
      .word     (sub_in),
      .sub_word (sub_out)
   );

   assign load_off = 3'(4'd8 - nk_of(ks.mode_i));
   assign rk_idx   = ks.rk_idx_i;

   always_comb begin
      rk_next = '0;
      if (valid_q && (rk_idx <= nr_q)) begin
         rk_next = {mem[AW'({rk_idx, 2'b00})], mem[AW'({rk_idx, 2'b01})],
                    mem[AW'({rk_idx, 2'b10})], mem[AW'({rk_idx, 2'b11})]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         mode_q   <= 2'b00;
         widx_q   <= '0;
         nk_cnt_q <= 3'd0;
         rcon_q   <= 8'h01;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
         nr_q     <= 4'd0;
         rk_q     <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         rk_q    <= rk_next;
         if (accept) begin
            mode_q   <= ks.mode_i;
            widx_q   <= AW'(nk_of(ks.mode_i));
            nk_cnt_q <= 3'd0;
            rcon_q   <= 8'h01;
            valid_q  <= 1'b0;
            nr_q     <= 4'd0;
         end else if (state_q == ST_EXPAND) begin
            widx_q   <= widx_q + 1'b1;
            nk_cnt_q <= rot_phase ? 3'(nk_of(mode_q) - 4'd1) : nk_cnt_q - 3'd1;
            if (rot_phase) rcon_q <= xtime(rcon_q);
            if (last_word) begin
               done_q  <= 1'b1;
               valid_q <= 1'b1;
               nr_q    <= nr_of(mode_q);
            end
         end
      end
   end

   // Storage and window carry no reset; keys_valid_o guards every read.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         for (int k = 0; k < 8; k++) begin
            win_q[k] <= key_w[3'(k) - load_off];
            if (4'(k) < nk_of(ks.mode_i)) mem[k] <= key_w[k];
         end
      end else if (state_q == ST_EXPAND) begin
         for (int k = 0; k < 7; k++) win_q[k] <= win_q[k+1];
         win_q[7]    <= new_w;
         mem[widx_q] <= new_w;
      end
   end

   assign ks.start_ready_o = (state_q == ST_IDLE);
   assign ks.busy_o        = (state_q == ST_EXPAND);
   assign ks.done_o        = done_q;
   assign ks.keys_valid_o  = valid_q;
   assign ks.nr_o          = nr_q;
   assign ks.rk_o          = rk_q;

endmodule

// File: tb/tb_aes_key_schedule_iter.sv
// Randomized bench for aes_key_schedule_iter against a FIPS-197 style key
// expansion model, with known-answer vectors pinning both model and DUT.
module tb_aes_key_schedule_iter;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   aes_key_schedule_iter_if #(.KEY_W(256), .IDX_W(4)) ks_if ();

   aes_key_schedule_iter #(.KEY_W(256), .NR_MAX(14), .IDX_W(4)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ks    (ks_if)
   );

   localparam logic [127:0] K128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [191:0] K192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] RK12  = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] RK14  = 128'hfe4890d1e6188d0b046df344706c631e;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   logic [7:0]   sbox_t [256];
   logic [7:0]   rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   logic [31:0]  m_sched [60];
   logic         m_ready = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_valid = 1'b0;
   logic [3:0]   m_nr = 4'd0, m_nr_pend = 4'd0;
   logic [127:0] m_rk = '0;
   int           m_left = 0;
   int           m_words = 0;
   int           cyc = 0;
   int           m_acc_cyc = 0;
   int           m_acc_n = 0;
   bit           m_live = 1'b0;
   logic [7:0]   sb_p, sb_q, sb_x;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] sub_word_m(logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   task automatic expand_model(input logic [1:0] mode, input logic [255:0] key);
      int nk, nr;
      logic [31:0] t;
      nk = (mode == 2'b01) ? 6 : (mode == 2'b10) ? 8 : 4;
      nr = nk + 6;
      for (int j = 0; j < nk; j++) m_sched[j] = key[255-32*j -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = m_sched[i-1];
         if (i % nk == 0)
            t = sub_word_m({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
         else if (nk == 8 && i % nk == 4)
            t = sub_word_m(t);
         m_sched[i] = m_sched[i-nk] ^ t;
      end
      m_nr_pend = 4'(nr);
      m_words   = 4*(nr+1) - nk;
   endtask

   always @(posedge clk_i) begin : model
      int ix;
      logic [127:0] rk_n;
      cyc++;
      ix   = int'(ks_if.rk_idx_i);
      rk_n = '0;
      if (m_valid && ix <= int'(m_nr))
         rk_n = {m_sched[4*ix], m_sched[4*ix+1], m_sched[4*ix+2], m_sched[4*ix+3]};
      if (rst_i) begin
         m_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0;
         m_nr = 4'd0; m_rk = '0; m_left = 0; m_live = 1'b1;
      end else begin
         m_rk   = rk_n;
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1; m_valid = 1'b1; m_nr = m_nr_pend;
               m_busy = 1'b0; m_ready = 1'b1;
            end
         end else if (ks_if.start_valid_i) begin
            expand_model(ks_if.mode_i, ks_if.key_i);
            m_left    = m_words;
            m_acc_cyc = cyc;
            m_acc_n++;
            m_valid = 1'b0; m_nr = 4'd0; m_busy = 1'b1; m_ready = 1'b0;
         end
      end
   end

   always @(negedge clk_i) begin
      if (m_live) begin
         chk("start_ready", ks_if.start_ready_o, m_ready);
         chk("busy",        ks_if.busy_o,        m_busy);
         chk("done",        ks_if.done_o,        m_done);
         chk("keys_valid",  ks_if.keys_valid_o,  m_valid);
         chk("nr",          ks_if.nr_o,          m_nr);
         chk("rk",          ks_if.rk_o,          m_rk);
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk_i);
         ks_if.rk_idx_i = 4'($urandom_range(0, 15));
      end
   endtask

   task automatic launch(input logic [1:0] mode, input logic [255:0] key);
      int n0;
      n0 = m_acc_n;
      ks_if.mode_i        = mode;
      ks_if.key_i         = key;
      ks_if.start_valid_i = 1'b1;
      for (int k = 0; k < 100 && m_acc_n == n0; k++) @(negedge clk_i);
      ks_if.start_valid_i = 1'b0;
      if (m_acc_n == n0) fail_timeout("accept");
   endtask

   task automatic wait_done(input int exp_lat, input string name);
      int k;
      k = 0;
      while (!ks_if.done_o && k < 200) begin
         @(negedge clk_i);
         ks_if.rk_idx_i = 4'($urandom_range(0, 15));
         k++;
      end
      if (!ks_if.done_o) fail_timeout(name);
      else chk(name, 128'(cyc - m_acc_cyc + 1), 128'(exp_lat));
   endtask

   task automatic read_rk(input int idx, input logic [127:0] exp, input string name);
      ks_if.rk_idx_i = 4'(idx);
      @(negedge clk_i);
      chk(name, ks_if.rk_o, exp);
   endtask

   task automatic sweep();
      for (int r = 0; r < 16; r++) begin
         ks_if.rk_idx_i = 4'(r);
         @(negedge clk_i);
      end
   endtask

   function automatic int lat_of(input logic [1:0] mode);
      case (mode)
         2'b01:   return 47;
         2'b10:   return 53;
         default: return 41;
      endcase
   endfunction

   initial begin
      int n0;
      logic [1:0] md;

      sb_p = 8'h01;
      sb_q = 8'h01;
      for (int n = 0; n < 255; n++) begin
         sb_p = sb_p ^ {sb_p[6:0], 1'b0} ^ (sb_p[7] ? 8'h1b : 8'h00);
         sb_q = sb_q ^ {sb_q[6:0], 1'b0};
         sb_q = sb_q ^ {sb_q[5:0], 2'b00};
         sb_q = sb_q ^ {sb_q[3:0], 4'b0000};
         if (sb_q[7]) sb_q = sb_q ^ 8'h09;
         sb_x = sb_q ^ {sb_q[6:0], sb_q[7]} ^ {sb_q[5:0], sb_q[7:6]} ^
                {sb_q[4:0], sb_q[7:5]} ^ {sb_q[3:0], sb_q[7:4]};
         sbox_t[sb_p] = sb_x ^ 8'h63;
      end
      sbox_t[0] = 8'h63;

      ks_if.start_valid_i = 1'b0;
      ks_if.mode_i        = 2'b00;
      ks_if.key_i         = '0;
      ks_if.rk_idx_i      = '0;

      repeat (3) @(negedge clk_i);
      chk("rst_ready", ks_if.start_ready_o, 1'b1);
      chk("rst_busy",  ks_if.busy_o,        1'b0);
      chk("rst_kv",    ks_if.keys_valid_o,  1'b0);
      chk("rst_nr",    ks_if.nr_o,          4'd0);
      chk("rst_rk",    ks_if.rk_o,          128'h0);
      chk("model_sbox_00", sbox_t[8'h00], 8'h63);
      chk("model_sbox_53", sbox_t[8'h53], 8'hed);
      rst_i = 1'b0;
      idle_cycles(2);

      // AES-128 known answer; low half of key_i is don't-care
      launch(2'b00, {K128, rnd128()});
      chk("model_rk1_128", {m_sched[4], m_sched[5], m_sched[6], m_sched[7]}, RK1);
      wait_done(41, "lat_aes128");
      chk("nr_aes128", ks_if.nr_o, 4'd10);
      read_rk(0,  K128,   "rk0_aes128");
      read_rk(1,  RK1,    "rk1_aes128");
      read_rk(10, RK10,   "rk10_aes128");
      read_rk(11, 128'h0, "rk11_aes128");

      // AES-192 known answer
      launch(2'b01, {K192, $urandom, $urandom});
      chk("model_rk12_192", {m_sched[48], m_sched[49], m_sched[50], m_sched[51]}, RK12);
      wait_done(47, "lat_aes192");
      chk("nr_aes192", ks_if.nr_o, 4'd12);
      read_rk(12, RK12,   "rk12_aes192");
      read_rk(13, 128'h0, "rk13_aes192");

      // AES-256 known answer
      launch(2'b10, K256);
      chk("model_rk14_256", {m_sched[56], m_sched[57], m_sched[58], m_sched[59]}, RK14);
      wait_done(53, "lat_aes256");
      chk("nr_aes256", ks_if.nr_o, 4'd14);
      read_rk(14, RK14,   "rk14_aes256");
      read_rk(15, 128'h0, "rk15_aes256");
      sweep();

      // start_valid held through EXPAND; second job accepted in the done cycle
      n0 = m_acc_n;
      ks_if.mode_i        = 2'b00;
      ks_if.key_i         = {rnd128(), rnd128()};
      ks_if.start_valid_i = 1'b1;
      for (int k = 0; k < 10 && m_acc_n == n0; k++) @(negedge clk_i);
      if (m_acc_n == n0) fail_timeout("hold_accept");
      ks_if.mode_i = 2'b10;
      ks_if.key_i  = {rnd128(), rnd128()};
      idle_cycles(5);
      chk("hold_ready_low", ks_if.start_ready_o, 1'b0);
      wait_done(41, "lat_hold_first");
      chk("hold_kv_done_cycle", ks_if.keys_valid_o, 1'b1);
      @(negedge clk_i);
      ks_if.start_valid_i = 1'b0;
      chk("hold_kv_drop", ks_if.keys_valid_o, 1'b0);
      chk("hold_busy_second", ks_if.busy_o, 1'b1);
      wait_done(53, "lat_hold_second");
      sweep();

      // reset 20 cycles into an AES-256 job
      launch(2'b10, {rnd128(), rnd128()});
      idle_cycles(20);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_busy",  ks_if.busy_o,        1'b0);
      chk("midrst_ready", ks_if.start_ready_o, 1'b1);
      chk("midrst_kv",    ks_if.keys_valid_o,  1'b0);
      chk("midrst_rk",    ks_if.rk_o,          128'h0);
      rst_i = 1'b0;
      idle_cycles(2);
      launch(2'b00, {rnd128(), rnd128()});
      wait_done(41, "lat_after_rst");
      sweep();

      // reserved mode behaves as AES-128
      launch(2'b11, {K128, rnd128()});
      wait_done(41, "lat_mode3");
      chk("nr_mode3", ks_if.nr_o, 4'd10);
      read_rk(1,  RK1,    "rk1_mode3");
      read_rk(10, RK10,   "rk10_mode3");
      read_rk(11, 128'h0, "rk11_mode3");

      // random jobs
      for (int j = 0; j < 8; j++) begin
         md = 2'($urandom_range(0, 3));
         idle_cycles($urandom_range(0, 4));
         launch(md, {rnd128(), rnd128()});
         wait_done(lat_of(md), "lat_random");
         sweep();
      end

      idle_cycles(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/aes_key_schedule_iter.md
Name: aes_key_schedule_iter

Overview:
Iterative, word-serial AES key schedule supporting AES-128, AES-192 and AES-256, selected per job by a mode input.
- Accepts a cipher key through a valid/ready handshake.
- Generates one 32-bit schedule word per clock and stores all round keys internally.
- Serves any round key through a registered, indexed read port.
- Replaces the fully unrolled 10-stage 128-bit expander in the cipher datapath, trading throughput for area and key-size flexibility.

Parameters:
- KEY_W, 256, width of key_i. Fixed to the largest supported key; other values are unsupported.
- NR_MAX, 14, maximum round count. Sizes storage at 4*(NR_MAX+1) = 60 words.
- IDX_W, 4, width of the round-key index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- start_valid_i  in  1  key job request
- start_ready_o  out  1  block can accept a job
- mode_i  in  2  key size: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved (treated as AES-128)
- key_i  in  KEY_W  cipher key, MSB-aligned; word 0 = key_i[255:224]
- busy_o  out  1  expansion in progress
- done_o  out  1  one-cycle pulse when the schedule is complete
- keys_valid_o  out  1  stored schedule is complete and current
- nr_o  out  4  round count of the stored schedule: 10 / 12 / 14
- rk_idx_i  in  IDX_W  round-key index
- rk_o  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, registered

Behaviour:
- Clock is clk_i only. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE, start_ready_o=1, busy_o=0, done_o=0, keys_valid_o=0, nr_o=0, rk_o=0. Key storage is not cleared.
- Per-mode constants:
  - AES-128: Nk=4, Nr=10, 44 words.
  - AES-192: Nk=6, Nr=12, 52 words.
  - AES-256: Nk=8, Nr=14, 60 words.
- States are IDLE and EXPAND.
- IDLE:
  - start_ready_o=1.
  - A job is accepted when start_valid_i and start_ready_o are both high at a clock edge (cycle T).
  - On acceptance: latch mode; write w[0..Nk-1] from key_i; set i=Nk and rcon=0x01; clear keys_valid_o; go to EXPAND.
- EXPAND:
  - start_ready_o=0 and busy_o=1. start_valid_i is ignored.
  - Each cycle writes one word: w[i] = w[i-Nk] ^ t, where t depends on i:
    - i mod Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0}, then rcon <= xtime(rcon) (0x80 -> 0x1b).
    - Nk == 8 and i mod Nk == 4: t = SubWord(w[i-1]).
    - otherwise: t = w[i-1].
  - i increments every cycle. After the write of the last word (i = 4*(Nr+1)-1), go to IDLE.
- Completion: in the first IDLE cycle after EXPAND, done_o=1 for exactly one cycle; keys_valid_o=1 and nr_o=Nr, both held until the next accept or reset.
- Latency from the accept edge to the done_o cycle: Nk + 4*(Nr+1) - 2*Nk + 1 cycles, i.e. 41 (AES-128), 47 (AES-192), 53 (AES-256).
- An accept in the done_o cycle is legal. keys_valid_o drops in the following cycle.
- Read port:
  - rk_o updates every clock from rk_idx_i; one-cycle latency.
  - If rk_idx_i > nr_o, or keys_valid_o=0, rk_o=0.
  - Simultaneous read and accept: the read is evaluated against pre-accept state.
- Reset mid-EXPAND: the next cycle is IDLE with reset values. A partially built schedule is never flagged valid.
- Rcon is 8 bits, computed with an iterative xtime. There is no lookup table.

Decomposition:
- Shared package aes_pkg holds:
  - mode encodings (AES128/192/256);
  - Nk/Nr lookup functions;
  - the sbox function;
  - the xtime function;
  - the state enum.
- One natural sub-module: aes_subword, 32-bit combinational (four S-box instances), reused by the cipher round logic.
- Word storage is a 60x32 register array, plus a sliding Nk-word window so that w[i-Nk] and w[i-1] need no wide read mux.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> done_o 41 cycles after accept; nr_o=10; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; idx11 = 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b (MSB-aligned) -> done_o at +47; idx12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done_o at +53; idx14 = fe4890d1e6188d0b046df344706c631e.
- start_valid_i held high during EXPAND -> start_ready_o=0, no re-accept; a second accept lands in the done_o cycle; keys_valid_o drops the next cycle; the second schedule completes correctly.
- rst_i asserted 20 cycles into an AES-256 job -> next cycle IDLE, keys_valid_o=0, rk_o=0. A new AES-128 job then yields correct keys.
- mode_i=11 with the AES-128 vector -> identical results to mode 00 (nr_o=10).
